// File: rtl/ysyx_23060201_ifu_prefetch.sv
// Instruction-fetch unit: sequential PC generation, one-outstanding memory request,
// DEPTH-entry prefetch FIFO towards the IDU, flushed on redirect.
//
// Handshakes: a request transfers when mem_req_valid && mem_req_ready, an instruction
// transfers when inst_valid && inst_ready, and mem_rsp_valid is a single-cycle strobe that
// completes the one outstanding request. Valid is never withdrawn before it transfers,
// except for mem_req_valid on redirect or reset.
module ysyx_23060201_ifu_prefetch #(
    parameter int               ADDR_W   = 32,
    parameter int               INST_W   = 32,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDR_W-1:0]        mem_req_addr,
    input  logic                     mem_rsp_valid,
    input  logic [INST_W-1:0]        mem_rsp_data,
    input  logic                     mem_rsp_err,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [INST_W-1:0]        inst,
    output logic [ADDR_W-1:0]        inst_pc,
    output logic                     inst_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [1:0]               dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_W / 8);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic [INST_W-1:0]  data_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
    logic               err_mem_q  [DEPTH];

    logic               push;
    logic               pop;
    logic               head_valid;
    logic [CNT_W-1:0]   cnt_after_pop;
    logic               has_space;
    logic               space_after_push;
    state_e             resume_state;

    assign head_valid = (count_q != '0);

    always_comb begin
        pop              = head_valid && inst_ready;
        cnt_after_pop    = count_q - CNT_W'(pop);
        has_space        = cnt_after_pop < DEPTH_C;
        space_after_push = (cnt_after_pop + CNT_W'(1)) < DEPTH_C;
        resume_state     = fetch_en ? S_REQ : S_IDLE;

        push       = 1'b0;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_en && has_space) state_d = S_REQ;
            end
            S_REQ: begin
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = (fetch_en && space_after_push) ? S_REQ : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mem_rsp_valid) state_d = resume_state;
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over push; a request still in flight must be drained first.
        if (redirect_valid) begin
            push       = 1'b0;
            fetch_pc_d = redirect_pc;
            case (state_q)
                S_IDLE:  state_d = resume_state;
                S_REQ:   state_d = mem_req_ready ? S_DRAIN : resume_state;
                default: state_d = mem_rsp_valid ? resume_state : S_DRAIN;
            endcase
        end

        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head outputs are gated by head_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= mem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            err_mem_q[wr_ptr_q]  <= mem_rsp_err;
        end
    end

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = fetch_pc_q;
    assign inst_valid    = head_valid;
    assign inst          = head_valid ? data_mem_q[rd_ptr_q] : '0;
    assign inst_pc       = head_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign inst_err      = head_valid ? err_mem_q[rd_ptr_q]  : 1'b0;
    assign fifo_count    = count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ysyx_23060201_ifu_prefetch.sv
// Bench for the prefetching IFU: a cycle table for start-up/back-pressure, a scoreboard
// of expected {err, pc, data} entries, and directed redirect, wrap and reset sequences.
module tb_ysyx_23060201_ifu_prefetch;

  localparam logic [31:0] DATA_KEY = 32'h1357_9bdf;
  localparam logic [31:0] PC_A     = 32'h8000_0000;
  localparam logic [31:0] PC_B     = 32'hffff_fff8;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_ready;
  logic        sel;

  logic        a_req_valid, b_req_valid, a_inst_valid, b_inst_valid, a_inst_err, b_inst_err;
  logic [31:0] a_req_addr, b_req_addr, a_inst, b_inst, a_inst_pc, b_inst_pc;
  logic [2:0]  a_count, b_count;
  logic [1:0]  a_state, b_state;

  logic        o_req_valid, o_inst_valid, o_inst_err;
  logic [31:0] o_req_addr, o_inst, o_inst_pc;
  logic [2:0]  o_count;

  ysyx_23060201_ifu_prefetch u_dut_a (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(a_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(a_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(a_inst_valid), .inst_ready(inst_ready), .inst(a_inst), .inst_pc(a_inst_pc),
    .inst_err(a_inst_err), .fifo_count(a_count), .dbg_state(a_state)
  );

  ysyx_23060201_ifu_prefetch #(.RESET_PC(32'hffff_fff8)) u_dut_b (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(b_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(b_inst_valid), .inst_ready(inst_ready), .inst(b_inst), .inst_pc(b_inst_pc),
    .inst_err(b_inst_err), .fifo_count(b_count), .dbg_state(b_state)
  );

  assign o_req_valid  = sel ? b_req_valid  : a_req_valid;
  assign o_req_addr   = sel ? b_req_addr   : a_req_addr;
  assign o_inst_valid = sel ? b_inst_valid : a_inst_valid;
  assign o_inst       = sel ? b_inst       : a_inst;
  assign o_inst_pc    = sel ? b_inst_pc    : a_inst_pc;
  assign o_inst_err   = sel ? b_inst_err   : a_inst_err;
  assign o_count      = sel ? b_count      : a_count;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [64:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] acc_addr;
  logic        outstanding;
  logic        drain;
  int          n_rsp;
  int          n_pop;
  int          n_cmp;
  int          n_fail;

  typedef struct {
    logic       fe, rr, rv, ir;
    logic       ev;
    logic [31:0] ea;
    logic       eiv;
    logic [2:0] ecnt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_pc      = sel ? PC_B : PC_A;
    acc_addr    = '0;
    outstanding = 1'b0;
    drain       = 1'b0;
    n_rsp       = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fetch_en = 0; redirect_valid = 0; redirect_pc = '0; mem_req_ready = 0;
    mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_err = 0; inst_ready = 0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Drive one cycle's inputs, account for the handshakes at the coming edge, then step.
  task automatic cycle(input logic fe, input logic rr, input logic rv, input logic ir,
                       input logic rd, input logic [31:0] rpc, input logic er);
    logic        fire, pop, keep;
    logic [64:0] e;
    fetch_en = fe; mem_req_ready = rr; mem_rsp_valid = rv; inst_ready = ir;
    redirect_valid = rd; redirect_pc = rpc; mem_rsp_err = er;
    mem_rsp_data = acc_addr ^ DATA_KEY;
    fire = o_req_valid && rr;
    pop  = o_inst_valid && ir;
    keep = rv && outstanding && !rd && !drain;
    if (fire) chk("req_addr", {32'h0, o_req_addr}, {32'h0, exp_pc});
    if (pop) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL pop_empty: got inst_pc %h expected no valid entry", o_inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("inst_pc",  {32'h0, o_inst_pc}, {32'h0, e[63:32]});
        chk("inst",     {32'h0, o_inst},    {32'h0, e[31:0]});
        chk("inst_err", {63'h0, o_inst_err}, {63'h0, e[64]});
      end
    end
    if (rd) exp_q.delete();
    if (keep) begin
      exp_q.push_back({er, acc_addr, acc_addr ^ DATA_KEY});
      exp_pc = exp_pc + 32'd4;
    end
    if (rv && outstanding) begin
      outstanding = 1'b0;
      drain = 1'b0;
      n_rsp++;
    end
    if (fire) begin
      outstanding = 1'b1;
      acc_addr = exp_pc;
    end
    if (rd) begin
      exp_pc = rpc;
      if (outstanding) drain = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic ir);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, outstanding, ir, 1'b0, '0, 1'b0);
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [31:0] ea,
                           input logic eiv, input logic [2:0] ecnt);
    chk({tag, ".req_valid"},  {63'h0, o_req_valid},  {63'h0, ev});
    chk({tag, ".req_addr"},   {32'h0, o_req_addr},   {32'h0, ea});
    chk({tag, ".inst_valid"}, {63'h0, o_inst_valid}, {63'h0, eiv});
    chk({tag, ".fifo_count"}, {61'h0, o_count},      {61'h0, ecnt});
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_pop = 0; sel = 1'b0;

    //          fe  rr  rv  ir  ev  ea             eiv cnt
    vecs[0]  = '{1, 1, 0, 0, 0, 32'h8000_0000, 0, 3'd0};
    vecs[1]  = '{1, 1, 0, 0, 1, 32'h8000_0000, 0, 3'd0};
    vecs[2]  = '{1, 1, 1, 0, 0, 32'h8000_0000, 0, 3'd0};
    vecs[3]  = '{1, 1, 0, 0, 1, 32'h8000_0004, 1, 3'd1};
    vecs[4]  = '{1, 1, 1, 0, 0, 32'h8000_0004, 1, 3'd1};
    vecs[5]  = '{1, 1, 0, 0, 1, 32'h8000_0008, 1, 3'd2};
    vecs[6]  = '{1, 1, 1, 0, 0, 32'h8000_0008, 1, 3'd2};
    vecs[7]  = '{1, 1, 0, 0, 1, 32'h8000_000c, 1, 3'd3};
    vecs[8]  = '{1, 1, 1, 0, 0, 32'h8000_000c, 1, 3'd3};
    vecs[9]  = '{1, 1, 0, 0, 0, 32'h8000_0010, 1, 3'd4};
    vecs[10] = '{1, 1, 0, 1, 0, 32'h8000_0010, 1, 3'd4};
    vecs[11] = '{1, 1, 0, 0, 1, 32'h8000_0010, 1, 3'd3};
    vecs[12] = '{1, 1, 1, 0, 0, 32'h8000_0010, 1, 3'd3};
    vecs[13] = '{1, 1, 0, 0, 0, 32'h8000_0014, 1, 3'd4};

    // reset values
    do_reset();
    chk_state("reset", 1'b0, PC_A, 1'b0, 3'd0);
    chk("reset.inst",     {32'h0, o_inst},     64'h0);
    chk("reset.inst_pc",  {32'h0, o_inst_pc},  64'h0);
    chk("reset.inst_err", {63'h0, o_inst_err}, 64'h0);

    // streaming fetch with a consumer that is always ready
    run(14, 1'b1);
    chk("stream.pops", (n_pop >= 5) ? 64'h1 : 64'h0, 64'h1);

    // cycle table: fill to DEPTH under back-pressure, then one pop buys one request
    do_reset();
    for (int i = 0; i < 14; i++) begin
      chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].eiv, vecs[i].ecnt);
      cycle(vecs[i].fe, vecs[i].rr, vecs[i].rv, vecs[i].ir, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk_state("full_hold", 1'b0, 32'h8000_0014, 1'b1, 3'd4);

    // redirect while waiting: the stale response is drained
    do_reset();
    cycle(1, 1, 0, 1, 0, '0, 0);
    cycle(1, 1, 0, 1, 0, '0, 0);
    cycle(1, 1, 0, 1, 1, 32'h8000_0100, 0);
    chk_state("drain", 1'b0, 32'h8000_0100, 1'b0, 3'd0);
    cycle(1, 1, 1, 1, 0, '0, 0);
    chk_state("after_drain", 1'b1, 32'h8000_0100, 1'b0, 3'd0);
    n_pop = 0;
    run(8, 1'b1);
    chk("redir_wait.pops", (n_pop >= 3) ? 64'h1 : 64'h0, 64'h1);

    // redirect and pop in the same cycle with three entries held
    do_reset();
    run(7, 1'b0);
    chk_state("fill3", 1'b1, 32'h8000_000c, 1'b1, 3'd3);
    cycle(1, 0, 0, 1, 1, 32'h8000_0200, 0);
    chk_state("redir_pop", 1'b1, 32'h8000_0200, 1'b0, 3'd0);
    run(10, 1'b1);

    // asynchronous reset in the middle of a wait
    do_reset();
    run(4, 1'b0);
    chk("pre_rst.inst_valid", {63'h0, o_inst_valid}, 64'h1);
    #3;
    rst = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, PC_A, 1'b0, 3'd0);
    chk("async_rst.inst_pc", {32'h0, o_inst_pc}, 64'h0);
    chk("async_rst.inst",    {32'h0, o_inst},    64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    cycle(1, 1, 1, 1, 0, '0, 0);
    chk_state("late_rsp", 1'b1, PC_A, 1'b0, 3'd0);
    run(8, 1'b1);

    // address wrap and an access fault on the second response
    sel = 1'b1;
    do_reset();
    chk_state("wrap_reset", 1'b0, PC_B, 1'b0, 3'd0);
    n_pop = 0;
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 1'b1, outstanding, 1'b1, 1'b0, '0, (outstanding && n_rsp == 1));
    chk("wrap.pops", (n_pop >= 3) ? 64'h1 : 64'h0, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
